serial_adder: RTL

//   Bit-serial WIDTH-bit adder built around one instance of the team's fa cell,

---
 rtl/serial_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa cell, one operand bit pair per clock, LSB first.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADDER_OVF_EN.

module fa (
    output logic cout,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic w_faSum;
    logic w_faCout;
    logic w_lastBit;

    fa u_fa (
        .cout (w_faCout),
        .sum  (w_faSum),
        .a    (r_aSh[0]),
        .b    (r_bSh[0]),
        .cin  (r_carry)
    );

    assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

    // In SHIFT, r_carry holds the carry into the bit being processed, so on the
    // last bit it is the carry into the MSB used for signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_aSh   <= a;
                        r_bSh   <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_sum   <= {w_faSum, r_sum[WIDTH-1:1]};
                    r_carry <= w_faCout;
                    r_aSh   <= r_aSh >> 1;
                    r_bSh   <= r_bSh >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_lastBit) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_faCout;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf   <= r_carry ^ w_faCout;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule
